// File: rtl/buzzer_sched_pkg.sv
// Shared definitions for buzzer_sched: FSM state encoding, the "no grant" id
// and the per-requester ON/OFF pattern lengths in ticks.
package buzzer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0] NO_ID = 2'd3;

    // Index i holds the pattern length for requester i.
    localparam logic [2:0][3:0] ON_TICKS  = {4'd1, 4'd3, 4'd2};
    localparam logic [2:0][3:0] OFF_TICKS = {4'd1, 4'd3, 4'd8};

    function automatic logic [3:0] on_ticks(input logic [1:0] id);
        case (id)
            2'd0:    on_ticks = ON_TICKS[0];
            2'd1:    on_ticks = ON_TICKS[1];
            2'd2:    on_ticks = ON_TICKS[2];
            default: on_ticks = ON_TICKS[0];
        endcase
    endfunction

    function automatic logic [3:0] off_ticks(input logic [1:0] id);
        case (id)
            2'd0:    off_ticks = OFF_TICKS[0];
            2'd1:    off_ticks = OFF_TICKS[1];
            2'd2:    off_ticks = OFF_TICKS[2];
            default: off_ticks = OFF_TICKS[0];
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Tick-based debouncer: the output level follows the input only after the
// input has differed from it for DEB_TICKS consecutive ticks.
module btn_debounce #(
    parameter int DEB_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic level
);
    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Stability counter; any return to the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (din == level_r) begin
            cnt_r <= '0;
        end else if (tick) begin
            if (cnt_r == CW'(DEB_TICKS - 1)) begin
                level_r <= din;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
endmodule

// File: rtl/buzzer_sched.sv
// Priority alarm buzzer scheduler with ON/OFF tick patterns and a mute button.
// Optional build macro BUZZER_SCHED_DEBOUNCE_EN debounces the button.
module buzzer_sched
    import buzzer_sched_pkg::*;
#(
    parameter int TONE_DIV  = 4,
    parameter int TICK_DIV  = 10,
    parameter int DEB_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       switch,
    output logic       buzzer,
    output logic [1:0] active_id,
    output logic       busy
);
    localparam int TKW = $clog2(TICK_DIV);
    localparam int TCW = $clog2(TONE_DIV + 1);

    if (TONE_DIV < 1 || TICK_DIV < 2 || DEB_TICKS < 1) begin : g_bad_params
    end

    logic            sw_meta_r, sw_sync_r, pb_prev_r, pb_level_s, press_s;
    logic [TKW-1:0]  tick_cnt_r;
    logic            tick_s;
    logic [2:0]      mute_r, mute_set_s, elig_s;
    logic            cand_valid_s, granted_ok_s;
    logic [1:0]      cand_id_s, id_r, id_s;
    state_t          state_r, state_s;
    logic [3:0]      pat_cnt_r, pat_cnt_s;
    logic [TCW-1:0]  tone_cnt_r, tone_cnt_s;
    logic            buzzer_r, buzzer_s, busy_r;

`ifdef BUZZER_SCHED_DEBOUNCE_EN
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick_s),
        .din   (sw_sync_r),
        .level (pb_level_s)
    );
`else
    assign pb_level_s = sw_sync_r;
`endif

    assign tick_s  = (tick_cnt_r == TKW'(TICK_DIV - 1));
    assign press_s = pb_level_s & ~pb_prev_r;
    assign elig_s  = req & ~mute_r;

    // Highest-index eligible requester wins, plus mute-set decode and grant health.
    always_comb begin
        cand_valid_s = |elig_s;
        mute_set_s   = 3'b000;
        granted_ok_s = 1'b0;
        if (elig_s[2]) begin
            cand_id_s = 2'd2;
        end else if (elig_s[1]) begin
            cand_id_s = 2'd1;
        end else begin
            cand_id_s = 2'd0;
        end
        case (id_r)
            2'd0:    granted_ok_s = elig_s[0];
            2'd1:    granted_ok_s = elig_s[1];
            2'd2:    granted_ok_s = elig_s[2];
            default: granted_ok_s = 1'b0;
        endcase
        if (press_s && busy_r) begin
            case (id_r)
                2'd0:    mute_set_s = 3'b001;
                2'd1:    mute_set_s = 3'b010;
                2'd2:    mute_set_s = 3'b100;
                default: mute_set_s = 3'b000;
            endcase
        end else begin
            mute_set_s = 3'b000;
        end
    end

    // Next state, grant, pattern counter and tone generation.
    always_comb begin
        state_s    = state_r;
        id_s       = id_r;
        pat_cnt_s  = pat_cnt_r;
        tone_cnt_s = '0;
        buzzer_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cand_valid_s) begin
                    state_s   = ST_ON;
                    id_s      = cand_id_s;
                    pat_cnt_s = on_ticks(cand_id_s);
                    buzzer_s  = 1'b1;
                end else begin
                    id_s = NO_ID;
                end
            end
            ST_ON: begin
                if (!granted_ok_s) begin
                    state_s   = ST_IDLE;
                    id_s      = NO_ID;
                    pat_cnt_s = 4'd0;
                end else if (tick_s && pat_cnt_r <= 4'd1) begin
                    state_s   = ST_OFF;
                    pat_cnt_s = off_ticks(id_r);
                end else begin
                    pat_cnt_s = tick_s ? pat_cnt_r - 4'd1 : pat_cnt_r;
                    if (tone_cnt_r == TCW'(TONE_DIV - 1)) begin
                        buzzer_s = ~buzzer_r;
                    end else begin
                        buzzer_s   = buzzer_r;
                        tone_cnt_s = tone_cnt_r + TCW'(1);
                    end
                end
            end
            ST_OFF: begin
                if (!granted_ok_s) begin
                    state_s   = ST_IDLE;
                    id_s      = NO_ID;
                    pat_cnt_s = 4'd0;
                end else if (tick_s && pat_cnt_r <= 4'd1) begin
                    // Pattern boundary: the only point where a higher requester preempts.
                    state_s   = ST_ON;
                    id_s      = cand_id_s;
                    pat_cnt_s = on_ticks(cand_id_s);
                    buzzer_s  = 1'b1;
                end else begin
                    pat_cnt_s = tick_s ? pat_cnt_r - 4'd1 : pat_cnt_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                id_s      = NO_ID;
                pat_cnt_s = 4'd0;
            end
        endcase
    end

    // All sequential state: synchronizer, prescaler, mute mask and FSM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_r  <= 1'b0;
            sw_sync_r  <= 1'b0;
            pb_prev_r  <= 1'b0;
            tick_cnt_r <= '0;
            mute_r     <= 3'b000;
            state_r    <= ST_IDLE;
            id_r       <= NO_ID;
            busy_r     <= 1'b0;
            pat_cnt_r  <= 4'd0;
            tone_cnt_r <= '0;
            buzzer_r   <= 1'b0;
        end else begin
            sw_meta_r  <= switch;
            sw_sync_r  <= sw_meta_r;
            pb_prev_r  <= pb_level_s;
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TKW'(1);
            mute_r     <= (mute_r | mute_set_s) & req;
            state_r    <= state_s;
            id_r       <= id_s;
            busy_r     <= (state_s != ST_IDLE);
            pat_cnt_r  <= pat_cnt_s;
            tone_cnt_r <= tone_cnt_s;
            buzzer_r   <= buzzer_s;
        end
    end

    assign buzzer    = buzzer_r;
    assign active_id = id_r;
    assign busy      = busy_r;
endmodule
